// File: rtl/reg_wb_scheduler.sv
// Single write-port scheduler for the 32-entry register file: arbitrates pipeline
// writeback against a long-latency unit and scoreboards pending long-latency writes.
module reg_wb_scheduler #(
    parameter int N            = 32,
    parameter int MAX_PEND     = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    input  logic         issue_long,
    input  logic [4:0]   issue_rs1,
    input  logic [4:0]   issue_rs2,
    input  logic [4:0]   issue_rd,
    output logic         issue_stall,
    input  logic         wb_valid,
    input  logic [4:0]   wb_rd,
    input  logic [N-1:0] wb_data,
    input  logic         lu_valid,
    input  logic [4:0]   lu_rd,
    input  logic [N-1:0] lu_data,
    output logic         lu_ready,
    output logic         pipe_hold,
    output logic         rf_we,
    output logic [4:0]   rf_rd,
    output logic [N-1:0] rf_wdata,
    output logic         err
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]   busy;
    logic [31:0]   busy_next;
    logic [31:0]   clr_vec;
    logic [31:0]   set_vec;
    logic [31:0]   eff_busy;
    logic [PW-1:0] pend_cnt;
    logic [PW-1:0] pend_after_clr;
    logic [PW-1:0] pend_next;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_next;
    logic          lu_fire;
    logic          lu_on_busy;
    logic          lu_stray;
    logic          wb_dropped;
    logic          pend_next_full;
    logic          hazard;
    logic          issue_set;

    // The pipeline owns the port unless a starvation bubble has been forced.
    always_comb begin
        lu_ready = 1'b0;
        if (!rst) begin
            lu_ready = pipe_hold ? 1'b1 : !wb_valid;
        end
        lu_fire = lu_valid && lu_ready;

        rf_rd    = wb_rd;
        rf_wdata = wb_data;
        rf_we    = 1'b0;
        if (lu_fire) begin
            rf_rd    = lu_rd;
            rf_wdata = lu_data;
            rf_we    = (lu_rd != 5'd0);
        end else if (!rst) begin
            rf_we = wb_valid && !pipe_hold && (wb_rd != 5'd0);
        end
    end

    // A register cleared this cycle is already readable thanks to the falling-edge write.
    always_comb begin
        lu_on_busy     = lu_fire && busy[lu_rd];
        lu_stray       = lu_fire && (lu_rd != 5'd0) && !busy[lu_rd];
        wb_dropped     = wb_valid && pipe_hold;
        clr_vec        = lu_fire ? (32'd1 << lu_rd) : 32'd0;
        eff_busy       = busy & ~clr_vec;
        pend_after_clr = pend_cnt - PW'(lu_on_busy);
        pend_next_full = (pend_after_clr == PW'(MAX_PEND));

        hazard = eff_busy[issue_rs1] | eff_busy[issue_rs2] | eff_busy[issue_rd]
               | (issue_long && pend_next_full);
        issue_stall = issue_valid && hazard && !rst;
        issue_set   = issue_valid && issue_long && !issue_stall && (issue_rd != 5'd0);
        set_vec     = issue_set ? (32'd1 << issue_rd) : 32'd0;

        busy_next = eff_busy | set_vec;
        pend_next = pend_after_clr + PW'(issue_set);
    end

    // Consecutive cycles in which the long-latency unit was refused the port.
    always_comb begin
        wait_next = wait_cnt;
        if (!lu_valid || lu_fire) begin
            wait_next = '0;
        end else if (wait_cnt < WW'(STARVE_LIMIT)) begin
            wait_next = wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 32'd0;
            pend_cnt  <= '0;
            wait_cnt  <= '0;
            pipe_hold <= 1'b0;
            err       <= 1'b0;
        end else begin
            busy      <= busy_next;
            pend_cnt  <= pend_next;
            wait_cnt  <= wait_next;
            pipe_hold <= (wait_next == WW'(STARVE_LIMIT));
            if (lu_stray || wb_dropped) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Bench for reg_wb_scheduler: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a pending-list reference model.
module tb_reg_wb_scheduler;

    localparam int N            = 32;
    localparam int MAX_PEND     = 4;
    localparam int STARVE_LIMIT = 4;

    logic         clk;
    logic         rst;
    logic         issue_valid;
    logic         issue_long;
    logic [4:0]   issue_rs1;
    logic [4:0]   issue_rs2;
    logic [4:0]   issue_rd;
    logic         issue_stall;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [N-1:0] wb_data;
    logic         lu_valid;
    logic [4:0]   lu_rd;
    logic [N-1:0] lu_data;
    logic         lu_ready;
    logic         pipe_hold;
    logic         rf_we;
    logic [4:0]   rf_rd;
    logic [N-1:0] rf_wdata;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Reference model: registers awaiting a long-latency result, blocked streak, flags.
    int pend_q[$];
    int m_starve = 0;
    bit m_hold   = 0;
    bit m_err    = 0;
    bit lu_held  = 0;

    reg_wb_scheduler #(
        .N(N),
        .MAX_PEND(MAX_PEND),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_long(issue_long),
        .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2),
        .issue_rd(issue_rd),
        .issue_stall(issue_stall),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .lu_valid(lu_valid),
        .lu_rd(lu_rd),
        .lu_data(lu_data),
        .lu_ready(lu_ready),
        .pipe_hold(pipe_hold),
        .rf_we(rf_we),
        .rf_rd(rf_rd),
        .rf_wdata(rf_wdata),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isPending(input int r);
        foreach (pend_q[i]) begin
            if (pend_q[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drives one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input bit iv, input bit il, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                                 input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(posedge clk);
        #1;
        issue_valid = iv;
        issue_long  = il;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        lu_valid    = lv;
        lu_rd       = lrd;
        lu_data     = ld;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        lu_valid    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Every negative edge: derive the expected outputs from the model, compare, then advance the model.
    always @(negedge clk) begin
        bit          e_rdy;
        bit          e_fire;
        bit          e_firep;
        bit          e_full;
        bit          e_stall;
        bit          e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        if (rst) begin
            checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
            checkOutput("rst_lu_ready", 32'(lu_ready), 32'd0);
            checkOutput("rst_issue_stall", 32'(issue_stall), 32'd0);
            checkOutput("rst_pipe_hold", 32'(pipe_hold), 32'd0);
            checkOutput("rst_err", 32'(err), 32'd0);
            pend_q.delete();
            m_starve = 0;
            m_hold   = 1'b0;
            m_err    = 1'b0;
            lu_held  = 1'b0;
        end else begin
            e_rdy   = m_hold || !wb_valid;
            e_fire  = lu_valid && e_rdy;
            e_firep = e_fire && isPending(int'(lu_rd));
            e_full  = (pend_q.size() - int'(e_firep)) == MAX_PEND;
            e_stall = issue_valid && (
                      (isPending(int'(issue_rs1)) && !(e_fire && lu_rd == issue_rs1)) ||
                      (isPending(int'(issue_rs2)) && !(e_fire && lu_rd == issue_rs2)) ||
                      (isPending(int'(issue_rd))  && !(e_fire && lu_rd == issue_rd))  ||
                      (issue_long && e_full));
            if (e_fire) begin
                e_we   = (lu_rd != 5'd0);
                e_rd   = lu_rd;
                e_data = lu_data;
            end else begin
                e_we   = wb_valid && !m_hold && (wb_rd != 5'd0);
                e_rd   = wb_rd;
                e_data = wb_data;
            end

            checkOutput("lu_ready", 32'(lu_ready), 32'(e_rdy));
            checkOutput("issue_stall", 32'(issue_stall), 32'(e_stall));
            checkOutput("rf_we", 32'(rf_we), 32'(e_we));
            if (e_we) begin
                checkOutput("rf_rd", 32'(rf_rd), 32'(e_rd));
                checkOutput("rf_wdata", rf_wdata, e_data);
            end
            checkOutput("pipe_hold", 32'(pipe_hold), 32'(m_hold));
            checkOutput("err", 32'(err), 32'(m_err));

            if ((e_fire && lu_rd != 5'd0 && !e_firep) || (wb_valid && m_hold)) m_err = 1'b1;
            if (e_firep) begin
                foreach (pend_q[i]) begin
                    if (pend_q[i] == int'(lu_rd)) begin
                        pend_q.delete(i);
                        break;
                    end
                end
            end
            if (issue_valid && issue_long && !e_stall && issue_rd != 5'd0) pend_q.push_back(int'(issue_rd));
            if (lu_valid && !e_fire) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else m_starve = 0;
            m_hold  = (m_starve == STARVE_LIMIT);
            lu_held = lu_valid && !e_fire;
        end
    end

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        issue_rd    = 5'd0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
        lu_valid    = 1'b0;
        lu_rd       = 5'd0;
        lu_data     = 32'd0;

        // Reset held while every input toggles.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            issue_valid = 1'b1;
            issue_long  = ($urandom_range(0, 1) == 1);
            issue_rs1   = 5'($urandom_range(0, 31));
            issue_rs2   = 5'($urandom_range(0, 31));
            issue_rd    = 5'($urandom_range(0, 31));
            wb_valid    = (i % 2 == 0);
            wb_rd       = 5'($urandom_range(1, 31));
            wb_data     = $urandom;
            lu_valid    = 1'b1;
            lu_rd       = 5'($urandom_range(1, 31));
            lu_data     = $urandom;
            @(negedge clk);
            checkOutput("t1_rf_we", 32'(rf_we), 32'd0);
            checkOutput("t1_lu_ready", 32'(lu_ready), 32'd0);
            checkOutput("t1_issue_stall", 32'(issue_stall), 32'd0);
            checkOutput("t1_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        lu_valid    = 1'b0;

        // RAW stall on rd=5 until its long-latency result, with same-cycle release.
        applyStimulus(1, 1, 5'd5, 5'd5, 5'd5, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("t2_first_issue_stall", 32'(issue_stall), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 5'd5, 5'd0, 5'd10, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            @(negedge clk);
            checkOutput("t2_raw_stall", 32'(issue_stall), 32'd1);
        end
        applyStimulus(1, 0, 5'd5, 5'd0, 5'd10, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("t2_bypass_stall", 32'(issue_stall), 32'd0);
        checkOutput("t2_rf_we", 32'(rf_we), 32'd1);
        checkOutput("t2_rf_rd", 32'(rf_rd), 32'd5);
        checkOutput("t2_rf_wdata", rf_wdata, 32'hDEADBEEF);
        applyStimulus(1, 0, 5'd5, 5'd0, 5'd10, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("t2_model_pend", 32'(pend_q.size()), 32'd0);
        @(negedge clk);
        checkOutput("t2_after_stall", 32'(issue_stall), 32'd0);

        // Starvation: four refused cycles, then one forced bubble.
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(1, 1, 5'd0, 5'd0, 5'd8, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            for (int k = 0; k < STARVE_LIMIT; k++) begin
                applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'h55, 1, 5'd8, 32'h1234);
                @(negedge clk);
                checkOutput("t3_blocked_ready", 32'(lu_ready), 32'd0);
                checkOutput("t3_blocked_hold", 32'(pipe_hold), 32'd0);
                checkOutput("t3_wb_rd", 32'(rf_rd), 32'd3);
            end
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, pass == 1, 5'd3, 32'h55, 1, 5'd8, 32'h1234);
            @(negedge clk);
            checkOutput("t3_hold", 32'(pipe_hold), 32'd1);
            checkOutput("t3_hold_ready", 32'(lu_ready), 32'd1);
            checkOutput("t3_lu_rd", 32'(rf_rd), 32'd8);
            checkOutput("t3_lu_wdata", rf_wdata, 32'h1234);
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'h66, 0, 5'd0, 32'd0);
            @(negedge clk);
            checkOutput("t3_hold_drop", 32'(pipe_hold), 32'd0);
            checkOutput("t3_wb_back", 32'(rf_we), 32'd1);
            checkOutput("t3_err", 32'(err), (pass == 1) ? 32'd1 : 32'd0);
        end
        doReset();

        // Outstanding limit: a fifth long issue waits for a commit.
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(1, 1, 5'd0, 5'd0, 5'(r), 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            @(negedge clk);
            checkOutput("t4_fill_stall", 32'(issue_stall), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 5'd0, 5'd0, 5'd6, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            @(negedge clk);
            checkOutput("t4_full_stall", 32'(issue_stall), 32'd1);
        end
        applyStimulus(1, 1, 5'd0, 5'd0, 5'd6, 0, 5'd0, 32'd0, 1, 5'd1, 32'h11);
        @(negedge clk);
        checkOutput("t4_release_stall", 32'(issue_stall), 32'd0);
        checkOutput("t4_release_rd", 32'(rf_rd), 32'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd2, 32'h22);
        checkOutput("t4_model_pend", 32'(pend_q.size()), 32'd4);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h33);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd4, 32'h44);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd6, 32'h66);
        idleCycle();
        checkOutput("t4_model_drained", 32'(pend_q.size()), 32'd0);

        // Re-issue of rd=7 in the cycle its previous result commits.
        applyStimulus(1, 1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(1, 1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
        @(negedge clk);
        checkOutput("t5_reissue_stall", 32'(issue_stall), 32'd0);
        checkOutput("t5_rf_we", 32'(rf_we), 32'd1);
        applyStimulus(1, 0, 5'd7, 5'd0, 5'd10, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("t5_model_pend", 32'(pend_q.size()), 32'd1);
        @(negedge clk);
        checkOutput("t5_still_busy", 32'(issue_stall), 32'd1);
        applyStimulus(1, 0, 5'd7, 5'd0, 5'd10, 0, 5'd0, 32'd0, 1, 5'd7, 32'h78);
        @(negedge clk);
        checkOutput("t5_clear_stall", 32'(issue_stall), 32'd0);
        idleCycle();

        // Stray result, x0 result and x0 writeback.
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd9, 32'hAA);
        @(negedge clk);
        checkOutput("t6_stray_we", 32'(rf_we), 32'd1);
        checkOutput("t6_stray_rd", 32'(rf_rd), 32'd9);
        checkOutput("t6_err_before", 32'(err), 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("t6_err_set", 32'(err), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("t6_err_sticky", 32'(err), 32'd1);
        doReset();
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hBB);
        @(negedge clk);
        checkOutput("t6_x0_lu_we", 32'(rf_we), 32'd0);
        checkOutput("t6_x0_lu_ready", 32'(lu_ready), 32'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hCC, 0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("t6_x0_lu_err", 32'(err), 32'd0);
        checkOutput("t6_x0_wb_we", 32'(rf_we), 32'd0);
        idleCycle();

        // Randomized traffic; the compare process checks every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rst         = ($urandom_range(0, 199) == 0);
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_long  = ($urandom_range(0, 1) == 1);
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            wb_valid    = m_hold ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) < 7);
            wb_rd       = 5'($urandom_range(0, 31));
            wb_data     = $urandom;
            if (!lu_held) begin
                lu_valid = ($urandom_range(0, 1) == 1);
                if (pend_q.size() > 0 && $urandom_range(0, 19) != 0)
                    lu_rd = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
                else
                    lu_rd = 5'($urandom_range(0, 31));
                lu_data = $urandom;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
